// File: rtl/vote_ballot_collector.sv
// Sequential ballot collector feeding the 16-input voting core: gathers one vote
// per voter over valid/ready, closes on full turnout or close, and holds the ballot until accepted.
module vote_ballot_collector #(
    parameter int NUM_VOTERS = 15,
    parameter int ID_W       = 4,
    parameter int QUORUM     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vote_valid,
    output logic                  vote_ready,
    input  logic [ID_W-1:0]       vote_id,
    input  logic                  vote_value,
    input  logic                  close,
    output logic                  ballot_valid,
    input  logic                  ballot_ready,
    output logic [NUM_VOTERS:0]   ballot_vec,
    output logic [ID_W-1:0]       votes_cast,
    output logic                  dup_err,
    output logic                  bad_id_err
);

    typedef enum logic {S_COLLECT, S_PRESENT} state_e;

    state_e                state_q, state_d;
    logic [NUM_VOTERS:0]   vec_q, vec_d;
    // Bit 0 of the mask is never set; it keeps indexing aligned with voter IDs.
    logic [NUM_VOTERS:0]   mask_q, mask_d;
    logic [ID_W-1:0]       cnt_q, cnt_d;
    logic                  dup_q, dup_d;
    logic                  bad_q, bad_d;
    logic                  id_ok;

    assign id_ok = (vote_id != '0) && (vote_id <= ID_W'(NUM_VOTERS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_COLLECT;
            vec_q   <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            dup_q   <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            dup_q   <= dup_d;
            bad_q   <= bad_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        dup_d   = 1'b0;
        bad_d   = 1'b0;
        case (state_q)
            S_COLLECT: begin
                if (vote_valid && vote_ready) begin
                    if (!id_ok) begin
                        bad_d = 1'b1;
                    end else if (mask_q[vote_id]) begin
                        dup_d = 1'b1;
                    end else begin
                        vec_d[vote_id]  = vote_value;
                        mask_d[vote_id] = 1'b1;
                        cnt_d           = cnt_q + 1'b1;
                    end
                end
                // Closure sees the count including this cycle's vote.
                if (cnt_d == ID_W'(NUM_VOTERS) || close) begin
                    vec_d[0] = (cnt_d >= ID_W'(QUORUM));
                    state_d  = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (ballot_valid && ballot_ready) begin
                    vec_d   = '0;
                    mask_d  = '0;
                    cnt_d   = '0;
                    state_d = S_COLLECT;
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end

    always_comb begin
        vote_ready   = (state_q == S_COLLECT);
        ballot_valid = (state_q == S_PRESENT);
    end

    assign ballot_vec = vec_q;
    assign votes_cast = cnt_q;
    assign dup_err    = dup_q;
    assign bad_id_err = bad_q;

endmodule

// File: tb/tb_vote_ballot_collector.sv
// Directed bench for vote_ballot_collector: one task per scenario, inline checks.
module tb_vote_ballot_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vote_valid;
    logic        vote_ready;
    logic [3:0]  vote_id;
    logic        vote_value;
    logic        close;
    logic        ballot_valid;
    logic        ballot_ready;
    logic [15:0] ballot_vec;
    logic [3:0]  votes_cast;
    logic        dup_err;
    logic        bad_id_err;

    int n_cmp = 0;
    int n_bad = 0;

    vote_ballot_collector #(.NUM_VOTERS(15), .ID_W(4), .QUORUM(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .vote_valid(vote_valid), .vote_ready(vote_ready),
        .vote_id(vote_id), .vote_value(vote_value), .close(close),
        .ballot_valid(ballot_valid), .ballot_ready(ballot_ready),
        .ballot_vec(ballot_vec), .votes_cast(votes_cast),
        .dup_err(dup_err), .bad_id_err(bad_id_err)
    );

    always #5 clk = ~clk;

    // Present a single-cycle vote; outputs are sampled 1 time unit after the edge.
    task automatic vote(input logic [3:0] id, input logic val);
        vote_valid = 1'b1; vote_id = id; vote_value = val;
        @(posedge clk); #1;
        vote_valid = 1'b0; vote_id = '0; vote_value = 1'b0;
    endtask

    task automatic do_close();
        close = 1'b1;
        @(posedge clk); #1;
        close = 1'b0;
    endtask

    task automatic handshake();
        ballot_ready = 1'b1;
        @(posedge clk); #1;
        ballot_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vote_valid = 1'b0; vote_id = '0; vote_value = 1'b0;
        close = 1'b0; ballot_ready = 1'b0;
        #12;
        n_cmp++; if (vote_ready !== 1'b1) begin n_bad++; $display("FAIL reset_vote_ready got %b want 1", vote_ready); end
        n_cmp++; if (ballot_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ballot_valid got %b want 0", ballot_valid); end
        n_cmp++; if (ballot_vec !== 16'h0) begin n_bad++; $display("FAIL reset_vec got %h want 0000", ballot_vec); end
        n_cmp++; if (votes_cast !== 4'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", votes_cast); end
        n_cmp++; if ({dup_err, bad_id_err} !== 2'b00) begin n_bad++; $display("FAIL reset_err got %b want 00", {dup_err, bad_id_err}); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_ballot();
        ballot_ready = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            n_cmp++; if (ballot_valid !== 1'b0) begin n_bad++; $display("FAIL full_early_valid id %0d got %b want 0", i, ballot_valid); end
            vote(4'(i), i[0]);
        end
        n_cmp++; if (ballot_valid !== 1'b1) begin n_bad++; $display("FAIL full_valid got %b want 1", ballot_valid); end
        n_cmp++; if (ballot_vec !== 16'hAAAB) begin n_bad++; $display("FAIL full_vec got %h want aaab", ballot_vec); end
        n_cmp++; if (votes_cast !== 4'd15) begin n_bad++; $display("FAIL full_cnt got %0d want 15", votes_cast); end
        n_cmp++; if (vote_ready !== 1'b0) begin n_bad++; $display("FAIL full_vote_ready got %b want 0", vote_ready); end
        @(posedge clk); #1;
        ballot_ready = 1'b0;
        n_cmp++; if ({vote_ready, ballot_valid} !== 2'b10) begin n_bad++; $display("FAIL full_return got %b want 10", {vote_ready, ballot_valid}); end
        n_cmp++; if (ballot_vec !== 16'h0 || votes_cast !== 4'd0) begin n_bad++; $display("FAIL full_cleared got %h/%0d want 0000/0", ballot_vec, votes_cast); end
    endtask

    task automatic test_early_close();
        vote(4'd3, 1'b1);
        vote(4'd7, 1'b1);
        n_cmp++; if (ballot_vec !== 16'h0088) begin n_bad++; $display("FAIL early_partial_vec got %h want 0088", ballot_vec); end
        do_close();
        n_cmp++; if (ballot_valid !== 1'b1) begin n_bad++; $display("FAIL early_valid got %b want 1", ballot_valid); end
        n_cmp++; if (ballot_vec !== 16'h0088) begin n_bad++; $display("FAIL early_vec got %h want 0088", ballot_vec); end
        n_cmp++; if (votes_cast !== 4'd2) begin n_bad++; $display("FAIL early_cnt got %0d want 2", votes_cast); end
        handshake();
        n_cmp++; if (ballot_valid !== 1'b0 || ballot_vec !== 16'h0) begin n_bad++; $display("FAIL early_cleared got %b/%h want 0/0000", ballot_valid, ballot_vec); end
    endtask

    task automatic test_dup_and_bad_id();
        vote(4'd5, 1'b1);
        n_cmp++; if (dup_err !== 1'b0) begin n_bad++; $display("FAIL dup_first got %b want 0", dup_err); end
        vote(4'd5, 1'b0);
        n_cmp++; if ({dup_err, bad_id_err} !== 2'b10) begin n_bad++; $display("FAIL dup_pulse got %b want 10", {dup_err, bad_id_err}); end
        n_cmp++; if (ballot_vec !== 16'h0020 || votes_cast !== 4'd1) begin n_bad++; $display("FAIL dup_state got %h/%0d want 0020/1", ballot_vec, votes_cast); end
        @(posedge clk); #1;
        n_cmp++; if (dup_err !== 1'b0) begin n_bad++; $display("FAIL dup_one_cycle got %b want 0", dup_err); end
        vote(4'd0, 1'b1);
        n_cmp++; if ({dup_err, bad_id_err} !== 2'b01) begin n_bad++; $display("FAIL bad_pulse got %b want 01", {dup_err, bad_id_err}); end
        n_cmp++; if (ballot_vec !== 16'h0020 || votes_cast !== 4'd1) begin n_bad++; $display("FAIL bad_state got %h/%0d want 0020/1", ballot_vec, votes_cast); end
        @(posedge clk); #1;
        n_cmp++; if (bad_id_err !== 1'b0) begin n_bad++; $display("FAIL bad_one_cycle got %b want 0", bad_id_err); end
        // Vote and close in the same cycle: the vote is counted before closure.
        close = 1'b1;
        vote(4'd2, 1'b1);
        close = 1'b0;
        n_cmp++; if (ballot_valid !== 1'b1 || ballot_vec !== 16'h0024 || votes_cast !== 4'd2) begin n_bad++; $display("FAIL vote_close got %b/%h/%0d want 1/0024/2", ballot_valid, ballot_vec, votes_cast); end
        handshake();
    endtask

    task automatic test_backpressure();
        for (int i = 1; i <= 8; i++) vote(4'(i), 1'b1);
        do_close();
        n_cmp++; if (ballot_vec !== 16'h01FF || votes_cast !== 4'd8) begin n_bad++; $display("FAIL bp_vec got %h/%0d want 01ff/8", ballot_vec, votes_cast); end
        for (int c = 0; c < 10; c++) begin
            vote_valid = c[0]; vote_id = 4'(c); vote_value = 1'b0; close = ~c[0];
            @(posedge clk); #1;
            n_cmp++;
            if (vote_ready !== 1'b0 || ballot_valid !== 1'b1 || ballot_vec !== 16'h01FF ||
                votes_cast !== 4'd8 || dup_err !== 1'b0 || bad_id_err !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold cyc %0d got rdy=%b vld=%b vec=%h cnt=%0d err=%b%b want 0/1/01ff/8/00",
                         c, vote_ready, ballot_valid, ballot_vec, votes_cast, dup_err, bad_id_err);
            end
        end
        vote_valid = 1'b0; vote_id = '0; close = 1'b0;
        handshake();
        n_cmp++; if (vote_ready !== 1'b1 || ballot_valid !== 1'b0 || ballot_vec !== 16'h0 || votes_cast !== 4'd0) begin n_bad++; $display("FAIL bp_release got rdy=%b vld=%b vec=%h cnt=%0d want 1/0/0000/0", vote_ready, ballot_valid, ballot_vec, votes_cast); end
    endtask

    task automatic test_reset_mid();
        vote(4'd1, 1'b1);
        vote(4'd2, 1'b1);
        do_close();
        n_cmp++; if (ballot_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre_valid got %b want 1", ballot_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (ballot_valid !== 1'b0 || ballot_vec !== 16'h0) begin n_bad++; $display("FAIL mid_async got %b/%h want 0/0000", ballot_valid, ballot_vec); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (vote_ready !== 1'b1 || votes_cast !== 4'd0) begin n_bad++; $display("FAIL mid_after got %b/%0d want 1/0", vote_ready, votes_cast); end
    endtask

    initial begin
        test_reset();
        test_full_ballot();
        test_early_close();
        test_dup_and_bad_id();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
